// File: rtl/pool_pkg.sv
// ----------------------------------------------------------------------------
// pool_pkg
// Shared definitions for the 2x2/stride-2 max-pool stage: FSM state encoding,
// buffer select codes, map geometry and pixel format, and the helper that turns
// a window position plus a tap index into an L0 read address.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
package pool_pkg;

    localparam int DATA_W   = 20;   // 4.16 unsigned fixed point
    localparam int FRAC_W   = 16;
    localparam int AW       = 12;
    localparam int IMG_DIM  = 64;   // layer-0 map is IMG_DIM x IMG_DIM
    localparam int POOL_DIM = 32;   // layer-1 map is POOL_DIM x POOL_DIM
    localparam int IDX_W    = $clog2(POOL_DIM);

    localparam logic [2:0] CSEL_NONE  = 3'b000;
    localparam logic [2:0] CSEL_L0_RD = 3'b001;
    localparam logic [2:0] CSEL_L1_WR = 3'b011;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD0  = 3'd1,
        S_RD1  = 3'd2,
        S_RD2  = 3'd3,
        S_RD3  = 3'd4,
        S_CMP  = 3'd5,
        S_WR   = 3'd6,
        S_FIN  = 3'd7
    } state_t;

    // Tap k of window (r,c): row 2r+k[1], column 2c+k[0] in a 64-wide map,
    // which packs to {r, k[1], c, k[0]}.
    function automatic logic [11:0] rd_addr(input logic [4:0] r,
                                            input logic [4:0] c,
                                            input logic [1:0] k);
        return {r, k[1], c, k[0]};
    endfunction

endpackage

// File: rtl/pool_max_ceil.sv
// ----------------------------------------------------------------------------
// pool_max_ceil
// Combinational datapath of the pool stage: running 2-input maximum and the
// result formatter applied to the final maximum.
// Optional feature macro: POOL_CEIL_EN -- when defined, the result is the
// maximum rounded up to the next integer (saturating at 15.0); when undefined
// the raw maximum is passed through.
// Ports:
//   cur_max   in   DATA_W  running maximum held by the caller
//   pixel     in   DATA_W  newly returned pixel
//   first     in   1       pixel is the first of its window (ignore cur_max)
//   next_max  out  DATA_W  updated running maximum
//   result    out  DATA_W  cur_max formatted for the L1 write
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module pool_max_ceil #(
    parameter int DATA_W = 20,
    parameter int FRAC_W = 16
) (
    input  logic [DATA_W-1:0] cur_max,
    input  logic [DATA_W-1:0] pixel,
    input  logic              first,
    output logic [DATA_W-1:0] next_max,
    output logic [DATA_W-1:0] result
);

    localparam int INT_W = DATA_W - FRAC_W;

    // Strict greater-than keeps the earlier pixel on a tie.
    always_comb begin
        if (first || (pixel > cur_max)) begin
            next_max = pixel;
        end else begin
            next_max = cur_max;
        end
    end

`ifdef POOL_CEIL_EN
    logic [INT_W:0] int_inc;   // one extra bit to catch overflow of the integer part

    assign int_inc = {1'b0, cur_max[DATA_W-1:FRAC_W]} + (INT_W+1)'(1);

    always_comb begin
        if (cur_max[FRAC_W-1:0] == '0) begin
            result = cur_max;
        end else if (int_inc[INT_W]) begin
            result = {{INT_W{1'b1}}, {FRAC_W{1'b0}}};
        end else begin
            result = {int_inc[INT_W-1:0], {FRAC_W{1'b0}}};
        end
    end
`else
    // Raw maximum, split at the binary point like the ceiling path.
    assign result = {cur_max[DATA_W-1:FRAC_W], cur_max[FRAC_W-1:0]};
`endif

endmodule

// File: rtl/maxpool_stage.sv
// ----------------------------------------------------------------------------
// maxpool_stage
// Layer-1 engine: reads the 64x64 layer-0 map from the L0 buffer, takes the
// maximum of every 2x2 window (stride 2) and writes the 32x32 result to L1.
// Each window costs 6 cycles: four reads, one compare slot for the last
// returned datum, one write.
// Optional feature macro: POOL_CEIL_EN (see pool_max_ceil).
// Ports:
//   clk       in   1       rising-edge clock
//   reset     in   1       asynchronous active-low reset
//   start     in   1       one-cycle request to pool the whole map (IDLE only)
//   busy      out  1       high while windows are being processed
//   done      out  1       one-cycle pulse after the final L1 write
//   crd       out  1       buffer read strobe
//   caddr_rd  out  AW      L0 read address
//   cdata_rd  in   DATA_W  read data, valid the cycle after crd
//   cwr       out  1       buffer write strobe
//   caddr_wr  out  AW      L1 write address
//   cdata_wr  out  DATA_W  write data
//   csel      out  3       buffer select (L0 on reads, L1 on writes, else none)
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module maxpool_stage #(
    parameter int DATA_W = pool_pkg::DATA_W,
    parameter int FRAC_W = pool_pkg::FRAC_W,
    parameter int AW     = pool_pkg::AW
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              crd,
    output logic [AW-1:0]     caddr_rd,
    input  logic [DATA_W-1:0] cdata_rd,
    output logic              cwr,
    output logic [AW-1:0]     caddr_wr,
    output logic [DATA_W-1:0] cdata_wr,
    output logic [2:0]        csel
);

    import pool_pkg::*;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(POOL_DIM - 1);

    state_t            state_reg;
    state_t            state_next;
    logic [IDX_W-1:0]  row_reg;
    logic [IDX_W-1:0]  col_reg;
    logic [DATA_W-1:0] max_reg;
    logic [DATA_W-1:0] max_next;
    logic [DATA_W-1:0] result;
    logic              last_window;
    logic              capture;
    logic              first_pixel;

    assign last_window = (row_reg == LAST_IDX) && (col_reg == LAST_IDX);

    // Data for the read issued in the previous state arrives in RD1..RD3 and CMP.
    assign capture     = (state_reg == S_RD1) || (state_reg == S_RD2) ||
                         (state_reg == S_RD3) || (state_reg == S_CMP);
    assign first_pixel = (state_reg == S_RD1);

    pool_max_ceil #(
        .DATA_W (DATA_W),
        .FRAC_W (FRAC_W)
    ) u_max (
        .cur_max  (max_reg),
        .pixel    (cdata_rd),
        .first    (first_pixel),
        .next_max (max_next),
        .result   (result)
    );

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ---------------- window counters and capture register ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row_reg <= '0;
            col_reg <= '0;
        end else if ((state_reg == S_IDLE) && start) begin
            row_reg <= '0;
            col_reg <= '0;
        end else if (state_reg == S_WR) begin
            // Row-major walk; both wrap to 0 after the last window.
            col_reg <= col_reg + IDX_W'(1);
            if (col_reg == LAST_IDX) begin
                row_reg <= row_reg + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            max_reg <= '0;
        end else if (capture) begin
            max_reg <= max_next;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (start) state_next = S_RD0;
            S_RD0:   state_next = S_RD1;
            S_RD1:   state_next = S_RD2;
            S_RD2:   state_next = S_RD3;
            S_RD3:   state_next = S_CMP;
            S_CMP:   state_next = S_WR;
            S_WR:    state_next = last_window ? S_FIN : S_RD0;
            S_FIN:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // ---------------- output logic ----------------
    always_comb begin
        busy     = 1'b0;
        done     = 1'b0;
        crd      = 1'b0;
        cwr      = 1'b0;
        caddr_rd = '0;
        caddr_wr = '0;
        cdata_wr = '0;
        csel     = CSEL_NONE;
        case (state_reg)
            S_RD0, S_RD1, S_RD2, S_RD3: begin
                busy     = 1'b1;
                crd      = 1'b1;
                csel     = CSEL_L0_RD;
                caddr_rd = AW'(rd_addr(row_reg, col_reg,
                                       2'(state_reg - S_RD0)));
            end
            S_CMP: begin
                busy = 1'b1;
            end
            S_WR: begin
                busy     = 1'b1;
                cwr      = 1'b1;
                csel     = CSEL_L1_WR;
                caddr_wr = AW'({row_reg, col_reg});
                cdata_wr = result;
            end
            S_FIN: begin
                done = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
